// File: rtl/spi_peripheral.sv
// SPI register-access peripheral: R/W bit, address and data shifted MSB-first on sclk falls, 3-wire sdio.
// Define SPI_PERIPH_ERR_COUNT_EN to build the saturating aborted-frame counter on err_count.
module spi_peripheral #(
  parameter int unsigned ADDR_BITS = 7,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs,
  inout  wire                  sdio,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [DATA_BITS-1:0] reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [DATA_BITS-1:0] reg_rdata,
  output logic                 frame_err,
  output logic [7:0]           err_count
);

  localparam int unsigned HDR_BITS  = 1 + ADDR_BITS;
  localparam int unsigned MAX_BITS  = (HDR_BITS > DATA_BITS) ? HDR_BITS : DATA_BITS;
  localparam int unsigned CNT_W     = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [2:0]           sclk_sh;
  logic [2:0]           cs_sh;
  logic [1:0]           sdio_sh;
  logic [CNT_W-1:0]     bit_cnt;
  logic [ADDR_BITS-1:0] hdr_sr;
  logic [DATA_BITS-1:0] wdata_sr;
  logic [DATA_BITS-1:0] rd_sr;
  logic                 rd_load;
  logic                 sdo_oe;

  logic fall_c, cs_rise_c, cs_fall_c, sdio_s_c;
  logic hdr_shift_c, addr_done_c, wdata_shift_c, wdata_done_c;
  logic rdata_shift_c, rdata_done_c, abort_c, hdr_rw_c;
  logic [ADDR_BITS-1:0] addr_c;

  // Synchronizers plus one history flop for edge detection; sclk/cs park high so reset never fakes a cs rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sh <= 3'b111;
      cs_sh   <= 3'b111;
      sdio_sh <= 2'b00;
    end else begin
      sclk_sh <= {sclk_sh[1:0], sclk};
      cs_sh   <= {cs_sh[1:0], cs};
      sdio_sh <= {sdio_sh[0], sdio};
    end
  end

  assign fall_c    = sclk_sh[2] & ~sclk_sh[1];
  assign cs_rise_c = ~cs_sh[2] & cs_sh[1];
  assign cs_fall_c = cs_sh[2] & ~cs_sh[1];
  assign sdio_s_c  = sdio_sh[1];
  assign hdr_rw_c  = hdr_sr[ADDR_BITS-1];
  assign addr_c    = ADDR_BITS'({hdr_sr, sdio_s_c});

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_rise_c) state_nxt = ADDR;
      ADDR: begin
        if (abort_c)          state_nxt = IDLE;
        else if (addr_done_c) state_nxt = hdr_rw_c ? RDATA : WDATA;
      end
      WDATA: begin
        if (abort_c)           state_nxt = IDLE;
        else if (wdata_done_c) state_nxt = DONE;
      end
      RDATA: begin
        if (abort_c)           state_nxt = IDLE;
        else if (rdata_done_c) state_nxt = DONE;
      end
      DONE:    if (cs_fall_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state actions; a cs drop takes priority over a same-cycle sclk fall.
  always_comb begin
    hdr_shift_c   = 1'b0;
    addr_done_c   = 1'b0;
    wdata_shift_c = 1'b0;
    wdata_done_c  = 1'b0;
    rdata_shift_c = 1'b0;
    rdata_done_c  = 1'b0;
    abort_c       = 1'b0;
    case (state)
      IDLE: hdr_shift_c = cs_rise_c & fall_c;
      ADDR: begin
        if (cs_fall_c) abort_c = 1'b1;
        else if (fall_c) begin
          hdr_shift_c = 1'b1;
          addr_done_c = (bit_cnt == HDR_LAST);
        end
      end
      WDATA: begin
        if (cs_fall_c) abort_c = 1'b1;
        else if (fall_c) begin
          wdata_shift_c = 1'b1;
          wdata_done_c  = (bit_cnt == DATA_LAST);
        end
      end
      RDATA: begin
        if (cs_fall_c) abort_c = 1'b1;
        else if (fall_c && !rd_load) begin
          rdata_shift_c = 1'b1;
          rdata_done_c  = (bit_cnt == DATA_LAST);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      hdr_sr    <= '0;
      wdata_sr  <= '0;
      rd_sr     <= '0;
      rd_load   <= 1'b0;
      sdo_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_we    <= wdata_done_c;
      reg_re    <= addr_done_c & hdr_rw_c;
      frame_err <= abort_c;
      rd_load   <= reg_re;

      if (state == IDLE && cs_rise_c) begin
        // A fall seen together with the cs rise is bit 0 of the new frame.
        bit_cnt <= fall_c ? CNT_W'(1) : '0;
        hdr_sr  <= ADDR_BITS'(sdio_s_c & fall_c);
      end else begin
        if (addr_done_c)
          bit_cnt <= '0;
        else if (hdr_shift_c || wdata_shift_c || rdata_shift_c)
          bit_cnt <= bit_cnt + CNT_W'(1);
        if (hdr_shift_c) hdr_sr <= ADDR_BITS'({hdr_sr, sdio_s_c});
      end

      if (addr_done_c)   reg_addr  <= addr_c;
      if (wdata_shift_c) wdata_sr  <= DATA_BITS'({wdata_sr, sdio_s_c});
      if (wdata_done_c)  reg_wdata <= DATA_BITS'({wdata_sr, sdio_s_c});

      if (state_nxt != RDATA) sdo_oe <= 1'b0;
      else if (rd_load)       sdo_oe <= 1'b1;

      if (rd_load && state == RDATA) rd_sr <= reg_rdata;
      else if (rdata_shift_c)        rd_sr <= rd_sr << 1;
    end
  end

  assign sdio = sdo_oe ? rd_sr[DATA_BITS-1] : 1'bz;

`ifdef SPI_PERIPH_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                               err_count <= 8'd0;
    else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: directed frames plus randomized frames against a frame-level model.
module tb_spi_peripheral;

  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 16;
  localparam int unsigned HALF = 4;
`ifdef SPI_PERIPH_ERR_COUNT_EN
  localparam logic [7:0] ERR_MASK = 8'hFF;
`else
  localparam logic [7:0] ERR_MASK = 8'h00;
`endif

  logic          clk;
  logic          reset;
  logic          sclk;
  logic          cs;
  logic          sdio_drv;
  logic          sdio_oe_m;
  wire           sdio;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [DW-1:0] reg_rdata;
  logic          frame_err;
  logic [7:0]    err_count;

  assign sdio = sdio_oe_m ? sdio_drv : 1'bz;
  pullup (sdio);

  spi_peripheral #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .sdio      (sdio),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int fe_cnt = 0;
  int exp_aborts;
  logic [AW-1:0] last_wa;
  logic [DW-1:0] last_wd;
  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] exp_mem [2**AW];

  function automatic logic [DW-1:0] pattern(input int a);
    return DW'(a * 40503) ^ 16'hC3A5;
  endfunction

  function automatic logic [7:0] exp_ec();
    return ((exp_aborts > 255) ? 8'd255 : 8'(exp_aborts)) & ERR_MASK;
  endfunction

  // Register file behind the peripheral, plus strobe monitors.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= pattern(i);
      reg_rdata <= '0;
    end else begin
      if (reg_we) begin
        mem[reg_addr] <= reg_wdata;
        we_cnt  <= we_cnt + 1;
        last_wa <= reg_addr;
        last_wd <= reg_wdata;
      end
      if (reg_re) begin
        reg_rdata <= mem[reg_addr];
        re_cnt    <= re_cnt + 1;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) exp_mem[i] = pattern(i);
    exp_aborts = 0;
  endtask

  // Master side of one frame: nbits sclk cycles; read data sampled at the end of each high phase.
  task automatic run_frame(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int nbits, input bit sync_start, input int rst_at,
                           output logic [DW-1:0] rd);
    logic [AW+DW:0] fr;
    fr = {rw, addr, data};
    rd = '0;
    if (!sync_start) begin
      cs = 1'b1;
      tick(4);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i < int'(AW + 1) || !rw) begin
        sdio_oe_m = 1'b1;
        sdio_drv  = (i < int'(AW + DW + 1)) ? fr[AW+DW-i] : 1'($urandom);
      end else begin
        sdio_oe_m = 1'b0;
      end
      tick(HALF);
      if (rw && i >= int'(AW + 1) && i < int'(AW + DW + 1)) rd[AW+DW-i] = sdio;
      if (i == rst_at) begin
        reset = 1'b1;
        tick(1);
        check("rst_sdio_z", sdio, 1);
        check("rst_outputs", {reg_addr, reg_wdata, reg_we, reg_re, frame_err, err_count}, 0);
        reset = 1'b0;
        model_reset();
      end
      if (i == 0 && sync_start) cs = 1'b1;
      sclk = 1'b0;
      tick(HALF);
      sclk = 1'b1;
    end
    sdio_oe_m = 1'b0;
    tick(HALF);
    cs = 1'b0;
    tick(8);
  endtask

  task automatic frame_check(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int nbits, input bit sync_start);
    int we0, re0, fe0;
    logic [DW-1:0] rd;
    bit complete;
    we0 = we_cnt;
    re0 = re_cnt;
    fe0 = fe_cnt;
    complete = (nbits >= int'(AW + DW + 1));
    run_frame(rw, addr, data, nbits, sync_start, -1, rd);
    check("we_pulses", 64'(we_cnt - we0), (!rw && complete) ? 1 : 0);
    check("re_pulses", 64'(re_cnt - re0), (rw && nbits >= int'(AW + 1)) ? 1 : 0);
    check("frame_err_pulses", 64'(fe_cnt - fe0), complete ? 0 : 1);
    if (!complete) exp_aborts++;
    if (complete) begin
      check("reg_addr", reg_addr, addr);
      if (rw) begin
        check("rd_data", rd, exp_mem[addr]);
      end else begin
        exp_mem[addr] = data;
        check("we_addr", last_wa, addr);
        check("we_data", last_wd, data);
        check("reg_wdata", reg_wdata, data);
      end
    end
    check("err_count", err_count, exp_ec());
    check("sdio_released", sdio, 1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int we0, re0, fe0;
    reset     = 1'b1;
    cs        = 1'b0;
    sclk      = 1'b1;
    sdio_oe_m = 1'b0;
    sdio_drv  = 1'b0;
    model_reset();
    tick(4);
    check("reset_outputs", {reg_addr, reg_wdata, reg_we, reg_re, frame_err, err_count}, 0);
    reset = 1'b0;
    tick(2);
    check("idle_sdio_z", sdio, 1);
    check("idle_err_count", err_count, 0);

    frame_check(1'b0, 7'h2A, 16'hBEEF, 24, 1'b0);
    frame_check(1'b0, 7'h05, 16'h1234, 24, 1'b0);
    frame_check(1'b1, 7'h05, 16'h0000, 24, 1'b0);
    frame_check(1'b0, 7'h2A, 16'hDEAD, 10, 1'b0);
    frame_check(1'b0, 7'h2A, 16'hCAFE, 24, 1'b0);
    frame_check(1'b0, 7'h11, 16'hA55A, 64, 1'b0);
    frame_check(1'b0, 7'h33, 16'h0F0F, 24, 1'b1);
    frame_check(1'b1, 7'h33, 16'h0000, 24, 1'b1);
    frame_check(1'b1, 7'h2A, 16'h0000, 8, 1'b0);

    // Reset while the peripheral is driving a 0 bit of a read.
    we0 = we_cnt;
    re0 = re_cnt;
    fe0 = fe_cnt;
    run_frame(1'b1, 7'h05, 16'h0000, 24, 1'b0, 12, rd);
    check("rst_frame_err", 64'(fe_cnt - fe0), 0);
    check("rst_we", 64'(we_cnt - we0), 0);
    check("rst_re", 64'(re_cnt - re0), 1);
    check("rst_sdio_after", sdio, 1);
    frame_check(1'b0, 7'h7F, 16'h0001, 24, 1'b0);
    frame_check(1'b1, 7'h7F, 16'h0000, 24, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            r, nbits;
      bit            ss;
      rw   = 1'($urandom);
      addr = AW'($urandom);
      data = DW'($urandom);
      r    = int'($urandom_range(0, 9));
      if (r < 6)      nbits = 24;
      else if (r < 8) nbits = int'($urandom_range(0, 23));
      else            nbits = 24 + int'($urandom_range(1, 12));
      ss = (nbits > 0) && ($urandom_range(0, 3) == 0);
      frame_check(rw, addr, data, nbits, ss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
